// File: rtl/dma_axi_pkg.sv
// Shared AXI encodings, FSM state types and address helpers for the DMA memory slave.
package dma_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the generic address helper; callers cast to their own width.
  localparam int unsigned NA_W = 64;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  // Address of the following beat: FIXED holds, anything else steps by 1<<size.
  function automatic logic [NA_W-1:0] next_addr(input logic [NA_W-1:0] addr,
                                                input logic [2:0]      size,
                                                input logic [1:0]      burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (NA_W'(1) << size);
  endfunction

  // WRAP (2'b10) and the reserved encoding (2'b11) are the ones this slave rejects.
  function automatic logic burst_ok(input logic [1:0] burst);
    return !burst[1];
  endfunction

endpackage

// File: rtl/dma_sram_bytes.sv
// Byte-enable SRAM: one write port, one registered read port, read-before-write.
module dma_sram_bytes #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned IDX_W      = 9
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI4 slave backed by an internal SRAM; independent single-burst read and write channels.
module dma_axi_mem_slave
  import dma_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int unsigned LANE_W = $clog2(STRB_WIDTH);
  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam int unsigned IDX_W  = MEM_AW - LANE_W;

  // Decoded when the address bits above the memory window match the base.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW];
  endfunction

  function automatic logic size_ok(input logic [2:0] size);
    return size <= 3'(LANE_W);
  endfunction

  // ---------------- write channel state ----------------
  wr_state_e             w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_wrap;

  logic                  w_hs_c;
  logic [ADDR_WIDTH-1:0] w_next_c;
  logic                  w_beat_err_c;
  logic                  mem_we_c;

  // ---------------- read channel state ----------------
  rd_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_wrap;
  logic                  r_zero;

  logic                  ar_hs_c;
  logic                  r_hs_c;
  logic                  ld_c;
  logic [ADDR_WIDTH-1:0] r_next_c;
  logic [ADDR_WIDTH-1:0] ld_addr_c;
  logic [2:0]            ld_size_c;
  logic [1:0]            ld_burst_c;
  logic                  ld_wrap_c;
  logic                  ld_err_c;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Per-beat write decode; a wrapped INCR address stays out of range for the rest of the burst.
  always_comb begin
    w_hs_c       = s_wvalid & s_wready;
    w_next_c     = ADDR_WIDTH'(next_addr(NA_W'(w_addr), w_size, w_burst));
    w_beat_err_c = !in_range(w_addr) | w_wrap | !size_ok(w_size) | !burst_ok(w_burst) |
                   (s_wlast != (w_cnt == w_len));
    mem_we_c     = w_hs_c & !w_beat_err_c & !rst;
  end

  // Write FSM: AW latch, data beats, then hold B until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_awvalid && s_awready) begin
            w_addr    <= s_awaddr;
            w_len     <= s_awlen;
            w_size    <= s_awsize;
            w_burst   <= s_awburst;
            s_bid     <= s_awid;
            w_cnt     <= 8'd0;
            w_err     <= 1'b0;
            w_wrap    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b1;
            w_state   <= W_DATA;
          end else begin
            s_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs_c) begin
            w_addr <= w_next_c;
            w_wrap <= w_wrap | (w_next_c < w_addr);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err | w_beat_err_c;
            if (s_wlast) begin
              s_wready <= 1'b0;
              s_bvalid <= 1'b1;
              s_bresp  <= (w_err | w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Next read beat: beat 0 comes straight from AR, later beats from the stepped address.
  always_comb begin
    ar_hs_c    = s_arvalid & s_arready;
    r_hs_c     = s_rvalid & s_rready;
    ld_c       = ar_hs_c | (r_hs_c & !s_rlast);
    r_next_c   = ADDR_WIDTH'(next_addr(NA_W'(r_addr), r_size, r_burst));
    ld_addr_c  = ar_hs_c ? s_araddr  : r_next_c;
    ld_size_c  = ar_hs_c ? s_arsize  : r_size;
    ld_burst_c = ar_hs_c ? s_arburst : r_burst;
    ld_wrap_c  = ar_hs_c ? 1'b0 : (r_wrap | (r_next_c < r_addr));
    ld_err_c   = !in_range(ld_addr_c) | ld_wrap_c | !size_ok(ld_size_c) | !burst_ok(ld_burst_c);
  end

  // Read FSM: one-cycle first-beat latency, back-to-back beats while rready stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rid     <= '0;
      r_zero    <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs_c) begin
            s_rid     <= s_arid;
            r_len     <= s_arlen;
            r_size    <= s_arsize;
            r_burst   <= s_arburst;
            r_cnt     <= 8'd0;
            s_arready <= 1'b0;
            s_rlast   <= (s_arlen == 8'd0);
            r_state   <= R_DATA;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs_c) begin
            if (s_rlast) begin
              s_rvalid  <= 1'b0;
              s_rlast   <= 1'b0;
              s_arready <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              s_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
      if (ld_c) begin
        r_addr   <= ld_addr_c;
        r_wrap   <= ld_wrap_c;
        s_rvalid <= 1'b1;
        s_rresp  <= ld_err_c ? RESP_SLVERR : RESP_OKAY;
        r_zero   <= ld_err_c;
      end
    end
  end

  // Error beats and the reset state present all-zero data.
  assign s_rdata = r_zero ? '0 : sram_rdata;

  dma_sram_bytes #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BYTES  (MEM_BYTES),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (w_addr[MEM_AW-1:LANE_W]),
    .wdata (s_wdata),
    .wstrb (s_wstrb),
    .re    (ld_c),
    .raddr (ld_addr_c[MEM_AW-1:LANE_W]),
    .rdata (sram_rdata)
  );

endmodule
